// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and 2-entry instruction buffer feeding decode
module instruction_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] instruction_address,
  input  logic [7:0] instruction_data,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [7:0] pc, pc0, w0, pc1, w1;
  logic [1:0] count;
  logic pop, push;
  assign instr_valid = count != 2'd0;
  assign pop = instr_valid && instr_ready && !branch_valid;
  assign push = state == RUN && !branch_valid && (count != 2'd2 || pop);
  assign instruction_address = pc;
  assign instr_out = w0;
  assign instr_pc = pc0;
  assign halted = state == HALT;
  // Next state: branch dominates, then start from IDLE, then halt detection on push
  always_comb begin
    state_n = state;
    state_n = branch_valid ? RUN :
              (state == IDLE && start) ? RUN :
              (push && instruction_data == HALT_OPCODE) ? HALT : state;
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // PC and buffer; entry 0 is always the head, so pops shift entry 1 down
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      count <= 2'd0;
      pc0 <= 8'h00;
      w0 <= 8'h00;
      pc1 <= 8'h00;
      w1 <= 8'h00;
    end else if (branch_valid) begin
      pc <= branch_target;
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        pc0 <= pc1;
        w0 <= w1;
      end
      if (push) begin
        pc <= pc + 8'd1;
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          pc0 <= pc;
          w0 <= instruction_data;
        end else begin
          pc1 <= pc;
          w1 <= instruction_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  logic clk = 0, reset = 1, start = 0, branch_valid = 0, instr_ready = 0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] instruction_address, instruction_data, instr_out, instr_pc;
  logic instr_valid, halted;
  logic [7:0] mem [256];
  logic [15:0] q[$];
  int checks = 0, errors = 0;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .instruction_address(instruction_address), .instruction_data(instruction_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .halted(halted)
  );

  always #5 clk = ~clk;
  assign instruction_data = mem[instruction_address];

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input logic [7:0] a);
    q.push_back({a, mem[a]});
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !branch_valid) begin
      if (q.size() == 0) check("extra_pop", 16'd1, 16'd0);
      else begin
        logic [15:0] e;
        e = q.pop_front();
        check("pc", {8'h00, instr_pc}, {8'h00, e[15:8]});
        check("word", {8'h00, instr_out}, {8'h00, e[7:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    do_reset();
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_addr", {8'h00, instruction_address}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_out", {8'h00, instr_out}, 16'h0000);
    check("rst_pc", {8'h00, instr_pc}, 16'h0000);
    // streaming with ready held high
    instr_ready = 1;
    for (int i = 0; i < 4; i++) expect_at(8'(i));
    start = 1;
    tick();
    start = 0;
    check("start_lat", {15'd0, instr_valid}, 16'd0);
    for (int i = 0; i < 5; i++) tick();
    instr_ready = 0;
    check("stream_drain", 16'(q.size()), 16'd0);
    // backpressure fills two entries then stalls
    do_reset();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_valid", {15'd0, instr_valid}, 16'd1);
    check("bp_addr", {8'h00, instruction_address}, 16'h0002);
    check("bp_out", {8'h00, instr_out}, 16'h0011);
    check("bp_pc", {8'h00, instr_pc}, 16'h0000);
    for (int i = 0; i < 3; i++) expect_at(8'(i));
    instr_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    instr_ready = 0;
    check("bp_drain", 16'(q.size()), 16'd0);
    // branch while full, concurrent ready must not accept flushed head
    branch_valid = 1;
    branch_target = 8'h80;
    instr_ready = 1;
    tick();
    branch_valid = 0;
    check("br_flush", {15'd0, instr_valid}, 16'd0);
    expect_at(8'h80);
    expect_at(8'h81);
    for (int i = 0; i < 3; i++) tick();
    instr_ready = 0;
    check("br_drain", 16'(q.size()), 16'd0);
    // halt opcode
    mem[2] = 8'hFF;
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 3; i++) expect_at(8'(i));
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_addr", {8'h00, instruction_address}, 16'h0003);
    check("halt_valid", {15'd0, instr_valid}, 16'd0);
    start = 1;
    tick();
    start = 0;
    tick();
    check("halt_hold", {15'd0, halted}, 16'd1);
    check("halt_frozen", {8'h00, instruction_address}, 16'h0003);
    check("halt_drain", 16'(q.size()), 16'd0);
    branch_valid = 1;
    branch_target = 8'h10;
    expect_at(8'h10);
    expect_at(8'h11);
    tick();
    branch_valid = 0;
    check("halt_exit", {15'd0, halted}, 16'd0);
    for (int i = 0; i < 3; i++) tick();
    instr_ready = 0;
    check("resume_drain", 16'(q.size()), 16'd0);
    // PC wrap
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[0] = 8'hCC;
    branch_valid = 1;
    branch_target = 8'hFE;
    instr_ready = 1;
    expect_at(8'hFE);
    expect_at(8'hFF);
    expect_at(8'h00);
    tick();
    branch_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    instr_ready = 0;
    check("wrap_drain", 16'(q.size()), 16'd0);
    // reset mid-stream with a full buffer
    tick();
    tick();
    check("mid_valid", {15'd0, instr_valid}, 16'd1);
    reset = 1;
    tick();
    reset = 0;
    check("mr_valid", {15'd0, instr_valid}, 16'd0);
    check("mr_addr", {8'h00, instruction_address}, 16'h0000);
    check("mr_halted", {15'd0, halted}, 16'd0);
    tick();
    tick();
    check("mr_idle", {15'd0, instr_valid}, 16'd0);
    check("mr_idle_addr", {8'h00, instruction_address}, 16'h0000);
    expect_at(8'h00);
    instr_ready = 1;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    instr_ready = 0;
    check("final_drain", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
